// File: rtl/adc_sampler.sv
// adc_sampler: periodic CS-framed reader for a 12-bit serial ADC (16 SCLK, MSB first).
// Define ADC_SAMPLER_AVG_EN to emit the truncated mean of every 4 consecutive codes instead.
module adc_sampler #(
   parameter int unsigned CLK_DIV       = 2,
   parameter int unsigned SAMPLE_PERIOD = 1000,
   parameter int unsigned QUIET_CYCLES  = 4
) (
   input  logic        clk_i,
   input  logic        reset_ni,
   input  logic        adc_sdata_i,
   output logic        adc_sclk_o,
   output logic        adc_cs_no,
   output logic [15:0] data_o,
   output logic        data_rdy_o,
   output logic        busy_o
);

   localparam int unsigned TimerW = $clog2(SAMPLE_PERIOD + 1);
   localparam int unsigned DivMax = (CLK_DIV > QUIET_CYCLES) ? CLK_DIV : QUIET_CYCLES;
   localparam int unsigned DivW   = $clog2(DivMax + 1);

   localparam logic [TimerW-1:0] TimerLast = TimerW'(SAMPLE_PERIOD - 1);
   localparam logic [DivW-1:0]   DivLast   = DivW'(CLK_DIV - 1);
   localparam logic [DivW-1:0]   QuietLast = DivW'(QUIET_CYCLES - 1);

   typedef enum logic [2:0] {StIdle, StSetup, StSclkLo, StSclkHi, StQuiet} state_e;

   state_e            state_q, state_d;
   logic [TimerW-1:0] timer_q;
   logic              tick;
   logic [DivW-1:0]   div_q, div_d;
   logic [4:0]        bit_q, bit_d;
   logic [11:0]       shift_q, shift_d;
   logic [15:0]       data_q, data_d;
   logic              rdy_q, rdy_d;
   logic              cs_n_q, cs_n_d;
   logic              sclk_q, sclk_d;
   logic              frame_done;
   logic              out_en;
   logic [11:0]       out_code;

   assign tick = (timer_q == TimerLast);

   // Sequencer; the divider counter is shared between SCLK phases and the quiet gap.
   always_comb begin
      state_d    = state_q;
      div_d      = div_q;
      bit_d      = bit_q;
      shift_d    = shift_q;
      frame_done = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (tick) begin
               state_d = StSetup;
               div_d   = '0;
               bit_d   = '0;
            end
         end
         StSetup: begin
            if (div_q == DivLast) begin
               state_d = StSclkLo;
               div_d   = '0;
            end else begin
               div_d = div_q + DivW'(1);
            end
         end
         StSclkLo: begin
            if (div_q == DivLast) begin
               state_d = StSclkHi;
               div_d   = '0;
               shift_d = {shift_q[10:0], adc_sdata_i};
               bit_d   = bit_q + 5'd1;
            end else begin
               div_d = div_q + DivW'(1);
            end
         end
         StSclkHi: begin
            if (div_q == DivLast) begin
               div_d = '0;
               if (bit_q < 5'd16) begin
                  state_d = StSclkLo;
               end else begin
                  state_d    = StQuiet;
                  frame_done = 1'b1;
               end
            end else begin
               div_d = div_q + DivW'(1);
            end
         end
         StQuiet: begin
            if (div_q == QuietLast) begin
               state_d = StIdle;
               div_d   = '0;
            end else begin
               div_d = div_q + DivW'(1);
            end
         end
         default: state_d = StIdle;
      endcase
      // Pin levels are registered from the next state so they never glitch.
      cs_n_d = !(state_d inside {StSetup, StSclkLo, StSclkHi});
      sclk_d = (state_d != StSclkLo);
   end

`ifdef ADC_SAMPLER_AVG_EN
   logic [13:0] acc_q, acc_d, sum;
   logic [1:0]  frm_q, frm_d;

   always_comb begin
      sum      = acc_q + 14'(shift_q);
      acc_d    = acc_q;
      frm_d    = frm_q;
      out_en   = 1'b0;
      out_code = sum[13:2];
      if (frame_done) begin
         if (frm_q == 2'd3) begin
            out_en = 1'b1;
            acc_d  = '0;
            frm_d  = '0;
         end else begin
            acc_d = sum;
            frm_d = frm_q + 2'd1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         acc_q <= '0;
         frm_q <= '0;
      end else begin
         acc_q <= acc_d;
         frm_q <= frm_d;
      end
   end
`else
   assign out_en   = frame_done;
   assign out_code = shift_q;
`endif

   always_comb begin
      data_d = out_en ? {4'b0000, out_code} : data_q;
      rdy_d  = out_en;
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q <= StIdle;
         timer_q <= '0;
         div_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         rdy_q   <= 1'b0;
         cs_n_q  <= 1'b1;
         sclk_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         timer_q <= tick ? '0 : timer_q + TimerW'(1);
         div_q   <= div_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         rdy_q   <= rdy_d;
         cs_n_q  <= cs_n_d;
         sclk_q  <= sclk_d;
      end
   end

   assign adc_cs_no  = cs_n_q;
   assign adc_sclk_o = sclk_q;
   assign data_o     = data_q;
   assign data_rdy_o = rdy_q;
   assign busy_o     = (state_q != StIdle);

endmodule

// File: tb/tb_adc_sampler.sv
// Scoreboard bench for adc_sampler: two instances (normal period, and a period shorter
// than a frame), each with a serial ADC model that pushes expected samples at frame start.
module tb_adc_sampler;

   localparam int CD      = 2;
   localparam int QC      = 4;
   localparam int SP_A    = 200;
   localparam int SP_B    = 40;
   localparam int LAT     = 1 + CD + 32 * CD;  // tick to strobe: 67
   localparam int TICK_A  = SP_A - 1;
   localparam int TICK_B  = SP_B - 1;
   localparam int PER_B   = 80;                // frame spans two ticks, so every other one is used

   logic        clk = 1'b0;
   logic        rst_a_n = 1'b1, rst_b_n = 1'b1;
   logic        sdata_a = 1'b0, sdata_b = 1'b0;
   logic        sclk_a, cs_a, rdy_a, busy_a;
   logic        sclk_b, cs_b, rdy_b, busy_b;
   logic [15:0] data_a, data_b;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   adc_sampler #(.CLK_DIV(CD), .SAMPLE_PERIOD(SP_A), .QUIET_CYCLES(QC)) dut_a (
      .clk_i(clk), .reset_ni(rst_a_n), .adc_sdata_i(sdata_a), .adc_sclk_o(sclk_a),
      .adc_cs_no(cs_a), .data_o(data_a), .data_rdy_o(rdy_a), .busy_o(busy_a)
   );

   adc_sampler #(.CLK_DIV(CD), .SAMPLE_PERIOD(SP_B), .QUIET_CYCLES(QC)) dut_b (
      .clk_i(clk), .reset_ni(rst_b_n), .adc_sdata_i(sdata_b), .adc_sclk_o(sclk_b),
      .adc_cs_no(cs_b), .data_o(data_b), .data_rdy_o(rdy_b), .busy_o(busy_b)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // {frame driven by ADC, hand-computed data_o}
   logic [31:0] vec_a [10] = '{
      32'h0100_0100, 32'h0101_0101, 32'h0102_0102, 32'h0103_0103, 32'h0ABC_0ABC,
      32'hFABC_0ABC, 32'h0000_0000, 32'h0FFF_0FFF, 32'hF000_0000, 32'h5A5A_0A5A
   };
   logic [15:0] fr_b [4] = '{16'h0111, 16'hA222, 16'h0333, 16'hF444};
   logic [15:0] ex_b [4] = '{16'h0111, 16'h0222, 16'h0333, 16'h0444};

   logic [31:0] stim_a[$];
   logic [15:0] exp_a[$], exp_b[$];
   logic [15:0] frame_a = '0, frame_b = '0;
   logic [13:0] acc_a = '0, acc_b = '0;
   int n_a = 0, n_b = 0, nb = 0;
   int bit_a = 0, bit_b = 0, rise_a = 0, rise_b = 0, hi_a = 1000, hi_b = 1000;
   int cyc_a = 0, cyc_b = 0;
   logic prev_cs_a = 1'b1, prev_sclk_a = 1'b1, prev_rdy_a = 1'b0;
   logic prev_cs_b = 1'b1, prev_sclk_b = 1'b1, prev_rdy_b = 1'b0;

   task automatic push_exp(input bit is_a, input logic [15:0] ex);
`ifdef ADC_SAMPLER_AVG_EN
      if (is_a) begin
         acc_a += 14'(ex[11:0]);
         n_a++;
         if (n_a == 4) begin
            exp_a.push_back({4'b0000, acc_a[13:2]});
            acc_a = '0;
            n_a   = 0;
         end
      end else begin
         acc_b += 14'(ex[11:0]);
         n_b++;
         if (n_b == 4) begin
            exp_b.push_back({4'b0000, acc_b[13:2]});
            acc_b = '0;
            n_b   = 0;
         end
      end
`else
      if (is_a) exp_a.push_back(ex);
      else exp_b.push_back(ex);
`endif
   endtask

   always @(posedge clk) begin
      cyc_a <= rst_a_n ? cyc_a + 1 : 0;
      cyc_b <= rst_b_n ? cyc_b + 1 : 0;
   end

   // ADC models and monitors, sampled mid-cycle.
   always @(negedge clk) begin
      if (!rst_a_n) begin
         prev_cs_a = 1'b1; prev_sclk_a = 1'b1; prev_rdy_a = 1'b0;
         rise_a = 0; hi_a = 1000; sdata_a = 1'b0;
      end else begin
         if (cs_a && hi_a < 1000) hi_a++;
         if (!cs_a && prev_cs_a) begin
            logic [31:0] v;
            chk("a_quiet_gap", 32'(hi_a > QC), 1);
            hi_a = 0; rise_a = 0; bit_a = 0;
            v = (stim_a.size() > 0) ? stim_a.pop_front() : 32'h0;
            frame_a = v[31:16];
            push_exp(1'b1, v[15:0]);
         end
         if (!cs_a && prev_sclk_a && !sclk_a) begin
            sdata_a = frame_a[4'(15 - bit_a)];
            bit_a++;
         end
         if (!cs_a && !prev_sclk_a && sclk_a) rise_a++;
         if (cs_a && !prev_cs_a) chk("a_sclk_rises", rise_a, 16);
         if (cs_a) chk("a_sclk_idle", sclk_a, 1);
         chk("a_busy", busy_a, 32'(!cs_a || hi_a <= QC));
         if (rdy_a) begin
            chk("a_rdy_single", prev_rdy_a, 0);
            chk("a_rdy_timing", (cyc_a - TICK_A) % SP_A, LAT);
            chk("a_rdy_expected", 32'(exp_a.size() > 0), 1);
            if (exp_a.size() > 0) chk("a_data", data_a, exp_a.pop_front());
         end
         prev_cs_a = cs_a; prev_sclk_a = sclk_a; prev_rdy_a = rdy_a;
      end

      if (rst_b_n) begin
         if (cs_b && hi_b < 1000) hi_b++;
         if (!cs_b && prev_cs_b) begin
            chk("b_quiet_gap", 32'(hi_b > QC), 1);
            hi_b = 0; rise_b = 0; bit_b = 0;
            frame_b = fr_b[nb % 4];
            push_exp(1'b0, ex_b[nb % 4]);
            nb++;
         end
         if (!cs_b && prev_sclk_b && !sclk_b) begin
            sdata_b = frame_b[4'(15 - bit_b)];
            bit_b++;
         end
         if (!cs_b && !prev_sclk_b && sclk_b) rise_b++;
         if (cs_b && !prev_cs_b) chk("b_sclk_rises", rise_b, 16);
         if (cs_b) chk("b_sclk_idle", sclk_b, 1);
         if (rdy_b) begin
            chk("b_rdy_single", prev_rdy_b, 0);
            chk("b_rdy_timing", (cyc_b - TICK_B) % PER_B, LAT);
            chk("b_rdy_expected", 32'(exp_b.size() > 0), 1);
            if (exp_b.size() > 0) chk("b_data", data_b, exp_b.pop_front());
         end
         prev_cs_b = cs_b; prev_sclk_b = sclk_b; prev_rdy_b = rdy_b;
      end
   end

   initial begin
      int guard;
      #2;
      rst_a_n = 1'b0;
      rst_b_n = 1'b0;
      #1;
      chk("rst_cs", cs_a, 1);
      chk("rst_sclk", sclk_a, 1);
      chk("rst_data", data_a, 0);
      chk("rst_rdy", rdy_a, 0);
      chk("rst_busy", busy_a, 0);
      for (int i = 0; i < 10; i++) stim_a.push_back(vec_a[i]);
      repeat (3) @(negedge clk);
      #1;
      rst_a_n = 1'b1;
      rst_b_n = 1'b1;

      while (cyc_a < 2100) @(posedge clk);
      chk("a_phase1_stim_used", stim_a.size(), 0);
      chk("a_phase1_drained", exp_a.size(), 0);

      // Abort a frame part-way through with reset.
      stim_a.push_back(32'h0123_0123);
      guard = 0;
      while (!(rise_a == 8 && !cs_a) && guard < 400) begin
         @(posedge clk);
         #2;
         guard++;
      end
      chk("a_reached_bit8", 32'(guard < 400), 1);
      rst_a_n = 1'b0;
      #1;
      chk("abort_cs", cs_a, 1);
      chk("abort_sclk", sclk_a, 1);
      chk("abort_data", data_a, 0);
      chk("abort_rdy", rdy_a, 0);
      chk("abort_busy", busy_a, 0);
      exp_a.delete();
      acc_a = '0;
      n_a   = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("abort_no_rdy", rdy_a, 0);
      end
      #1;
      rst_a_n = 1'b1;

      stim_a.push_back(32'h0321_0321);
      stim_a.push_back(32'hF7E1_07E1);
      while (cyc_a < 560) @(posedge clk);
      chk("a_phase2_stim_used", stim_a.size(), 0);
      chk("a_phase2_drained", exp_a.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
